serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the team's existing half adder: two half_adder instances plus an OR form a full-adder cell, a carry flip-flop closes the loop, and shift registers stream operands LSB-first. Sits downstream of the combinational half_adder/full-adder primitives as the first clocked arithmetic block, trading WIDTH cycles of latency for a single 1-bit adder cell. Start/done handshake toward a controller or testbench.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width,
// and the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // A 1-bit operand still needs a 1-bit counter, so clamp $clog2 at 1.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Full-adder cell composed of two half adders and an OR on their carries;
// shared by the serial adder and later ripple arithmetic blocks.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  logic w_partSum;
  logic w_partCarry;
  logic w_finalCarry;

  half_adder u_haLow (
    .A     (A),
    .B     (B),
    .Sum   (w_partSum),
    .Carry (w_partCarry)
  );

  half_adder u_haHigh (
    .A     (w_partSum),
    .B     (Cin),
    .Sum   (Sum),
    .Carry (w_finalCarry)
  );

  assign Carry = w_partCarry | w_finalCarry;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder: the basic 1-bit primitive of the arithmetic library.
module half_adder (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B;
  assign Carry = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// operands streamed LSB-first, start/done handshake toward the controller.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int             CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sumSr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carryFf;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic             w_cellSum;
  logic             w_cellCarry;
  logic [WIDTH-1:0] w_sumNext;

  full_adder u_cell (
    .A     (r_aSr[0]),
    .B     (r_bSr[0]),
    .Cin   (r_carryFf),
    .Sum   (w_cellSum),
    .Carry (w_cellCarry)
  );

  // New sum bits enter at the MSB so the LSB-first stream ends up in place.
  generate
    if (WIDTH == 1) begin : g_single
      assign w_sumNext = w_cellSum;
    end else begin : g_multi
      assign w_sumNext = {w_cellSum, r_sumSr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_aSr     <= '0;
      r_bSr     <= '0;
      r_sumSr   <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_carryFf <= 1'b0;
      r_carry   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_aSr     <= r_aSr >> 1;
          r_bSr     <= r_bSr >> 1;
          r_sumSr   <= w_sumNext;
          r_carryFf <= w_cellCarry;
          if (r_cnt == LAST) begin
            r_sum   <= w_sumNext;
            r_carry <= w_cellCarry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // IDLE and DONE both accept a new request, which gives back-to-back issue.
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_aSr     <= A;
            r_bSr     <= B;
            r_sumSr   <= '0;
            r_cnt     <= '0;
            r_carryFf <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign Sum   = r_sum;
  assign Carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance checked
// every cycle against a transaction-level model, plus directed literal cases.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] A8 = '0;
  logic [7:0] B8 = '0;
  logic       busy8, done8, Carry8;
  logic [7:0] Sum8;

  logic start1 = 1'b0;
  logic A1 = 1'b0;
  logic B1 = 1'b0;
  logic busy1, done1, Carry1;
  logic Sum1;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .Sum(Sum8), .Carry(Carry8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Carry(Carry1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is accepted whenever not busy, its result
  // {Carry,Sum} = A+B appears WIDTH edges later together with a done pulse.
  logic       mBusy8 = 0, mDone8 = 0, mCarry8 = 0;
  logic [7:0] mSum8 = '0;
  logic [8:0] pend8 = '0;
  int         left8 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy8 = 0; mDone8 = 0; mSum8 = '0; mCarry8 = 0; left8 = 0;
    end else if (mBusy8) begin
      left8--;
      if (left8 == 0) begin
        mBusy8 = 0; mDone8 = 1;
        {mCarry8, mSum8} = pend8;
      end
    end else begin
      mDone8 = 0;
      if (start8) begin
        pend8  = {1'b0, A8} + {1'b0, B8};
        mBusy8 = 1;
        left8  = 8;
      end
    end
  end

  logic       mBusy1 = 0, mDone1 = 0, mCarry1 = 0, mSum1 = 0;
  logic [1:0] pend1 = '0;
  int         left1 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy1 = 0; mDone1 = 0; mSum1 = 0; mCarry1 = 0; left1 = 0;
    end else if (mBusy1) begin
      left1--;
      if (left1 == 0) begin
        mBusy1 = 0; mDone1 = 1;
        {mCarry1, mSum1} = pend1;
      end
    end else begin
      mDone1 = 0;
      if (start1) begin
        pend1  = {1'b0, A1} + {1'b0, B1};
        mBusy1 = 1;
        left1  = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy8", 32'(busy8), 32'(mBusy8));
      checkOutput("done8", 32'(done8), 32'(mDone8));
      checkOutput("sum8", 32'(Sum8), 32'(mSum8));
      checkOutput("carry8", 32'(Carry8), 32'(mCarry8));
      checkOutput("busyDone8Excl", 32'(busy8 & done8), 32'd0);
      checkOutput("busy1", 32'(busy1), 32'(mBusy1));
      checkOutput("done1", 32'(done1), 32'(mDone1));
      checkOutput("sum1", 32'(Sum1), 32'(mSum1));
      checkOutput("carry1", 32'(Carry1), 32'(mCarry1));
      checkOutput("busyDone1Excl", 32'(busy1 & done1), 32'd0);
    end
  end

  // Issue one addition to the 8-bit instance and pin result and latency.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] expSum, input logic expCarry);
    int cyc;
    @(negedge clk);
    A8 = a; B8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("lit8_doneSeen", 32'(done8), 32'd1);
    checkOutput("lit8_latency", 32'(cyc), 32'd9);
    checkOutput("lit8_sum", 32'(Sum8), 32'(expSum));
    checkOutput("lit8_carry", 32'(Carry8), 32'(expCarry));
  endtask

  task automatic applyStimulus1(input logic a, input logic b,
                                input logic expSum, input logic expCarry);
    int cyc;
    @(negedge clk);
    A1 = a; B1 = b; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("lit1_doneSeen", 32'(done1), 32'd1);
    checkOutput("lit1_latency", 32'(cyc), 32'd2);
    checkOutput("lit1_sum", 32'(Sum1), 32'(expSum));
    checkOutput("lit1_carry", 32'(Carry1), 32'(expCarry));
  endtask

  initial begin
    int cyc;
    bit sawDone;
    logic [1:0] s2;

    #2 rst = 1'b1;
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_sum", 32'(Sum8), 32'd0);
    checkOutput("rst_carry", 32'(Carry8), 32'd0);
    rst = 1'b0;

    applyStimulus8(8'd3, 8'd5, 8'd8, 1'b0);
    applyStimulus8(8'd255, 8'd1, 8'd0, 1'b1);
    applyStimulus8(8'd0, 8'd0, 8'd0, 1'b0);
    applyStimulus8(8'd170, 8'd85, 8'd255, 1'b0);

    // Back-to-back with start held high across the DONE cycle.
    @(negedge clk);
    A8 = 8'd200; B8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    A8 = 8'd1; B8 = 8'd2;
    cyc = 1;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("b2b_first_sum", 32'(Sum8), 32'd44);
    checkOutput("b2b_first_carry", 32'(Carry8), 32'd1);
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("b2b_gap", 32'(cyc), 32'd9);
    checkOutput("b2b_second_sum", 32'(Sum8), 32'd3);
    checkOutput("b2b_second_carry", 32'(Carry8), 32'd0);

    // Start and operand changes while busy must be ignored.
    @(negedge clk);
    A8 = 8'd10; B8 = 8'd20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; A8 = 8'd99; B8 = 8'd77;
    repeat (2) @(negedge clk);
    start8 = 1'b1; A8 = 8'd250; B8 = 8'd250;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("hold_sum_busy", 32'(Sum8), 32'd3);
    cyc = 4;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("ignore_sum", 32'(Sum8), 32'd30);
    checkOutput("ignore_carry", 32'(Carry8), 32'd0);

    // Asynchronous abort in the middle of RUN.
    @(negedge clk);
    A8 = 8'd100; B8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_sum", 32'(Sum8), 32'd0);
    checkOutput("abort_carry", 32'(Carry8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
    end
    checkOutput("abort_noDone", 32'(sawDone), 32'd0);
    applyStimulus8(8'd7, 8'd9, 8'd16, 1'b0);

    // Width-1 instance: exhaustive operands, expectation from plain addition.
    applyStimulus1(1'b1, 1'b1, 1'b0, 1'b1);
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        s2 = 2'(a + b);
        applyStimulus1(a[0], b[0], s2[0], s2[1]);
      end
    end

    // Random traffic on both instances, including one asynchronous abort.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 3) != 0);
      A8     = 8'($urandom);
      B8     = 8'($urandom);
      start1 = ($urandom_range(0, 2) != 0);
      A1     = 1'($urandom);
      B1     = 1'($urandom);
      if (i == 300) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
    repeat (12) @(negedge clk);
    checkEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
